// File: rtl/ysyx_23060111_ifu_if.sv
// Fetch-side signal bundle: instruction memory request/response, the
// instruction stream toward decode, the redirect from execute and the
// visible fetch PC. The master side is the fetch unit.
interface ysyx_23060111_ifu_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_23060111_ifu.sv
// Instruction fetch unit. Issues one instruction read at a time, holds the
// returned word for decode until accepted, and follows redirects from
// execute. A response that belongs to a superseded address is discarded
// through the drop flag.
module ysyx_23060111_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  ysyx_23060111_ifu_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state, state_n;
  logic        drop, drop_n;
  logic [31:0] pc, pc_n;
  logic [31:0] inst_q, inst_pc_q;
  logic        capture;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};

  // Outputs come only from state and registers, never from inputs.
  assign bus.mem_req_valid = (state == S_REQ);
  assign bus.mem_req_addr  = pc;
  assign bus.inst_valid    = (state == S_HOLD);
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.pc            = pc;

  // Next-state, next-PC and drop decisions; redirect wins every conflict.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    state_n = state;
    drop_n  = drop;
    pc_n    = pc;
    capture = 1'b0;
    case (state)
      S_IDLE: begin
        state_n = S_REQ;
        if (bus.redirect_valid) pc_n = redirect_tgt;
      end
      S_REQ: begin
        if (bus.mem_req_ready) state_n = S_WAIT;
        if (bus.redirect_valid) begin
          pc_n = redirect_tgt;
          // The old-address request is already accepted; its reply is stale.
          if (bus.mem_req_ready) drop_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          // The single outstanding reply is consumed here either way.
          state_n = S_REQ;
          drop_n  = 1'b0;
          if (!bus.redirect_valid && !drop) begin
            capture = 1'b1;
            state_n = S_HOLD;
          end
        end else if (bus.redirect_valid) begin
          drop_n = 1'b1;
        end
        if (bus.redirect_valid) pc_n = redirect_tgt;
      end
      default: begin // S_HOLD
        if (bus.redirect_valid) begin
          // Flush the held word; a same-cycle inst_ready is not a handshake.
          pc_n    = redirect_tgt;
          state_n = S_REQ;
        end else if (bus.inst_ready) begin
          pc_n    = pc + 32'd4;
          state_n = S_REQ;
        end
      end
    endcase
  end

  // Control state: FSM, stale-response flag and fetch PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      drop  <= 1'b0;
      pc    <= RESET_PC;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_n;
      drop  <= drop_n;
      pc    <= pc_n;
    end
  end

  // Instruction holding register, loaded only on an accepted response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
    end else if (capture) begin
      inst_q    <= bus.mem_rsp_data;
      inst_pc_q <= pc;
    end
  end

endmodule

// File: doc/ysyx_23060111_ifu.md
# ysyx_23060111_ifu

Instruction fetch unit: the producer on the `inst` interface that the instruction decode stage consumes. It holds the fetch PC and issues one 32-bit instruction read at a time to instruction memory over a request/response handshake. It presents each returned word with its PC to decode over a valid/ready handshake, and redirects fetch on a jump or branch target from execute. At most one memory request is outstanding; stale responses after a redirect are discarded.

## Interface
- `RESET_PC`, default 32'h8000_0000, PC loaded on reset.
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `mem_req_valid`  out  1  read request to instruction memory
- `mem_req_addr`  out  32  request address, equals `pc` while `mem_req_valid`
- `mem_req_ready`  in  1  memory accepts request this cycle
- `mem_rsp_valid`  in  1  read data valid; always accepted, no backpressure
- `mem_rsp_data`  in  32  read data
- `inst_valid`  out  1  `inst`/`inst_pc` valid toward decode
- `inst`  out  32  fetched instruction word
- `inst_pc`  out  32  address of `inst`
- `inst_ready`  in  1  decode accepts `inst` this cycle
- `redirect_valid`  in  1  fetch redirect from execute (jal, jalr, taken branch)
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored, treated as 0
- `pc`  out  32  current fetch PC

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Internal `drop` flag marks the outstanding response as stale.
- **IDLE:** entered only from reset. Goes to REQ on the next edge.
- **REQ:**
  - `mem_req_valid`=1 with `mem_req_addr`=`pc`.
  - On `mem_req_ready`=1, goes to WAIT.
  - Address is stable while waiting unless a redirect occurs.
- **WAIT:**
  - Responses are sampled only in this state.
  - On `mem_rsp_valid`=1 with `drop`=0: capture `inst`←`mem_rsp_data`, `inst_pc`←`pc`, then go to HOLD.
  - On `mem_rsp_valid`=1 with `drop`=1: discard the data, clear `drop`, go to REQ.
- **HOLD:**
  - `inst_valid`=1; `inst` and `inst_pc` are held stable until the handshake.
  - On `inst_ready`=1: `pc`←`pc`+4 (mod 2^32, wraps), go to REQ.
- **Redirect** (`redirect_valid`=1) has priority over every other event in the same cycle. `pc`←{`redirect_pc`[31:2],2'b00} in all cases.
  - IDLE: `pc` updated, state still goes to REQ.
  - REQ with `mem_req_ready`=0: stay in REQ; the new address is presented next cycle.
  - REQ with `mem_req_ready`=1: the old-address request is accepted. Go to WAIT with `drop`←1.
  - WAIT: `drop`←1. A response arriving in the same cycle is discarded; go to REQ.
  - WAIT with `drop` already 1: only `pc` changes.
  - HOLD: the held instruction is flushed. `inst_valid` falls, go to REQ. A same-cycle `inst_ready` does not count as a handshake; decode must ignore it. `pc` is not incremented.
- `mem_rsp_valid` outside WAIT is ignored. The memory must not produce it, since only one request is ever outstanding.

## Timing
- **Reset values** (immediate on `rst_n`=0, no clock needed):
  - state IDLE, `drop`=0, `pc`=`RESET_PC`
  - `mem_req_valid`=0, `mem_req_addr`=`RESET_PC`
  - `inst_valid`=0, `inst`=0, `inst_pc`=0
- **First request:**
  - The first edge with `rst_n`=1 moves IDLE→REQ.
  - `mem_req_valid` rises after that edge, one cycle after release.
- **Latency:**
  - Request acceptance to earliest response: 1 cycle (response in the cycle after acceptance).
  - Response to `inst_valid`: 1 cycle (registered).
  - Decode handshake to next `mem_req_valid`: 1 cycle.
- **Throughput:** with zero-wait memory and decode, one instruction every 3 cycles (REQ, WAIT, HOLD).
- **Redirect to new-address request:**
  - From REQ or HOLD: `mem_req_addr`=target in the next cycle.
  - From WAIT: after the stale response returns, plus 1 cycle.
- **Mid-operation reset:** aborts any state. A response arriving after release while in IDLE/REQ is ignored, and `drop` is cleared.
- **Outputs:** all outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- **Reset and first fetch:** hold `rst_n`=0 for 3 cycles.
  - During reset: `mem_req_valid`=0 and `pc`=32'h8000_0000.
  - Release with `mem_req_ready`=1 and a response of 32'h0010_0093 one cycle after acceptance.
  - Required: `inst_valid`=1, `inst`=32'h0010_0093, `inst_pc`=32'h8000_0000.
- **Sequential stream:** zero-wait memory and `inst_ready`=1 held.
  - Required: `inst_pc` sequence 32'h8000_0000, 32'h8000_0004, 32'h8000_0008, one instruction every 3 cycles.
- **Backpressure:**
  - `inst_ready`=0 for 5 cycles in HOLD: `inst`/`inst_pc` stable, `mem_req_valid`=0.
  - `inst_ready`=1: next request address is `inst_pc`+4.
- **Redirect in WAIT:**
  - Redirect to 32'h8000_0100 while a response is pending; response returns 32'hDEAD_BEEF.
  - Required: no `inst_valid` for that word. Next request addr is 32'h8000_0100 and its response is delivered with `inst_pc`=32'h8000_0100.
- **Redirect in HOLD with simultaneous `inst_ready`:**
  - Target 32'h8000_0203.
  - Required: `inst_valid` drops, next `mem_req_addr`=32'h8000_0200, `pc` not incremented.
- **Wrap and reset mid-WAIT:**
  - Set `pc`=32'hFFFF_FFFC via redirect and complete a handshake: next addr is 32'h0000_0000.
  - Assert `rst_n`=0 during WAIT: outputs return to reset values immediately; a late response after release is ignored.
